// File: rtl/mux_n_arb.sv
// Registered N:1 valid/ready channel mux with explicit-select or round-robin grant.
// Define MUX_N_ARB_SKID_EN to add a skid entry that cuts the out_ready -> in_ready path.
module mux_n_arb #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 4,
    parameter int SEL_W      = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mode_i,
    input  logic [SEL_W-1:0]             sel_i,
    input  logic [NUM_IN-1:0]            in_valid_i,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data_i,
    output logic [NUM_IN-1:0]            in_ready_o,
    output logic                         out_valid_o,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic [SEL_W-1:0]             out_chan_o,
    input  logic                         out_ready_i
);

    function automatic logic [NUM_IN-1:0] chan_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_IN-1:0] vec;
        vec = {NUM_IN{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            if (idx == SEL_W'(i)) begin
                vec[i] = 1'b1;
            end else begin
                vec[i] = 1'b0;
            end
        end
        return vec;
    endfunction

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]      out_chan_q,  out_chan_d;
    logic [SEL_W-1:0]      rr_ptr_q,    rr_ptr_d;

    logic                  grant_vld_s;
    logic [SEL_W-1:0]      grant_idx_s;
    logic [DATA_WIDTH-1:0] grant_data_s;
    logic                  load_en_s;
    logic                  in_take_s;
    logic                  accept_s;
    int                    rr_idx_s;

    assign load_en_s = ~out_valid_q | out_ready_i;

    // Grant selection: sel match in explicit mode, first requester after rr_ptr otherwise
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {SEL_W{1'b0}};
        rr_idx_s    = 0;
        if (mode_i == 1'b0) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if ((sel_i == SEL_W'(i)) && in_valid_i[i]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = SEL_W'(i);
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_IN; k++) begin
                rr_idx_s = int'(rr_ptr_q) + k;
                if (rr_idx_s >= NUM_IN) begin
                    rr_idx_s = rr_idx_s - NUM_IN;
                end else begin
                    rr_idx_s = rr_idx_s;
                end
                for (int i = 0; i < NUM_IN; i++) begin
                    if (!grant_vld_s && (rr_idx_s == i) && in_valid_i[i]) begin
                        grant_vld_s = 1'b1;
                        grant_idx_s = SEL_W'(i);
                    end else begin
                        grant_vld_s = grant_vld_s;
                    end
                end
            end
        end
    end

    // Winning channel's data word
    always_comb begin
        grant_data_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx_s == SEL_W'(i)) begin
                grant_data_s = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                grant_data_s = grant_data_s;
            end
        end
    end

    assign accept_s   = grant_vld_s & in_take_s;
    assign in_ready_o = (grant_vld_s && in_take_s) ? chan_onehot(grant_idx_s) : {NUM_IN{1'b0}};

    // Round-robin pointer advances only on an accepted input
    always_comb begin
        if (accept_s) begin
            rr_ptr_d = grant_idx_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

`ifdef MUX_N_ARB_SKID_EN
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [SEL_W-1:0]      skid_chan_q,  skid_chan_d;

    // Only registered state gates acceptance, so a full skid blocks new inputs
    assign in_take_s = ~skid_valid_q;

    // Output/skid next state: skid drains first to keep order
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_chan_d  = skid_chan_q;
        if (load_en_s) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_chan_d   = skid_chan_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data_s;
                out_chan_d  = grant_idx_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = grant_data_s;
                skid_chan_d  = grant_idx_s;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // Skid register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= {DATA_WIDTH{1'b0}};
            skid_chan_q  <= {SEL_W{1'b0}};
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_chan_q  <= skid_chan_d;
        end
    end
`else
    assign in_take_s = load_en_s;

    // Output next state: load on accept, clear valid on a plain drain
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data_s;
            out_chan_d  = grant_idx_s;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end
`endif

    // Output register and arbitration pointer; reset pointer makes channel 0 win first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_WIDTH{1'b0}};
            out_chan_q  <= {SEL_W{1'b0}};
            rr_ptr_q    <= SEL_W'(NUM_IN - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_chan_o  = out_chan_q;

endmodule
